// File: rtl/ascon_substitution_layer.sv
// Ascon-128 substitution layer (pS).
// Applies the 5-bit S-box to every one of the 64 bit-slice columns of the
// 320-bit state, then registers the result one cycle after capture.

package ascon_pack;
    // Five 64-bit words; element 0 is S0 and element 4 is S4.
    typedef logic [4:0][63:0] type_state;
endpackage

module ascon_substitution_layer
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      enable_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      valid_o
);

    type_state sub_state;
    type_state state_d;
    type_state state_q;
    logic      valid_d;
    logic      valid_q;

    // Bit-sliced Ascon S-box for one column.
    // The input is {S0,S1,S2,S3,S4} with S0 as the MSB, and the output uses the same order.
    // The sequence is: xor in, and-not chi, xor out, then invert the S2 slice.
    function automatic logic [4:0] sbox_column(input logic [4:0] x);
        logic x0, x1, x2, x3, x4;
        logic t0, t1, t2, t3, t4;
        x0 = x[4];
        x1 = x[3];
        x2 = x[2];
        x3 = x[1];
        x4 = x[0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    // One independent S-box per column; no column depends on any other.
    for (genvar i = 0; i < 64; i++) begin : g_column
        logic [4:0] col_y;
        assign col_y = sbox_column({state_i[0][i], state_i[1][i], state_i[2][i],
                                    state_i[3][i], state_i[4][i]});
        assign sub_state[0][i] = col_y[4];
        assign sub_state[1][i] = col_y[3];
        assign sub_state[2][i] = col_y[2];
        assign sub_state[3][i] = col_y[1];
        assign sub_state[4][i] = col_y[0];
    end

    // Next-state logic: on capture, take the substituted state; otherwise hold the output.
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        if (enable_i) begin
            state_d = sub_state;
            valid_d = 1'b1;
        end
    end

    // Output register; a synchronous reset clears any pending result and overrides capture.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign state_o = state_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_ascon_substitution_layer.sv
// Directed testbench for ascon_substitution_layer.
// The expected values are hand-computed constants or come from a table-driven S-box model.

module tb_ascon_substitution_layer;
    import ascon_pack::*;

    logic      clock_i;
    logic      reset_i;
    logic      enable_i;
    type_state state_i;
    type_state state_o;
    logic      valid_o;

    int errors;
    int checks;

    ascon_substitution_layer dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .valid_o  (valid_o)
    );

    // Free-running clock with a 10-unit period.
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Reference S-box, indexed by the column value {S0,S1,S2,S3,S4}.
    function automatic logic [4:0] sbox_ref(input logic [4:0] x);
        logic [4:0] tbl [32];
        tbl = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        return tbl[x];
    endfunction

    // Column-by-column software model of the whole layer.
    function automatic type_state model(input type_state s);
        type_state  r;
        logic [4:0] x;
        logic [4:0] y;
        for (int i = 0; i < 64; i++) begin
            x = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
            y = sbox_ref(x);
            r[0][i] = y[4];
            r[1][i] = y[3];
            r[2][i] = y[2];
            r[3][i] = y[1];
            r[4][i] = y[0];
        end
        return r;
    endfunction

    // Builds a state in which every column holds the same 5-bit value x.
    function automatic type_state sweep_state(input logic [4:0] x);
        type_state s;
        s[0] = {64{x[4]}};
        s[1] = {64{x[3]}};
        s[2] = {64{x[2]}};
        s[3] = {64{x[1]}};
        s[4] = {64{x[0]}};
        return s;
    endfunction

    function automatic type_state random_state();
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [319:0] actual,
                               input logic [319:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives the inputs, then advances past the next rising edge so the outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic en, input type_state s);
        reset_i  = rst;
        enable_i = en;
        state_i  = s;
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        type_state exp_s;
        type_state prev_out;
        type_state in_s;

        errors   = 0;
        checks   = 0;
        reset_i  = 1'b1;
        enable_i = 1'b1;
        state_i  = '0;

        // Reset wins over enable, applied for two cycles with random data.
        applyStimulus(1'b1, 1'b1, random_state());
        applyStimulus(1'b1, 1'b1, random_state());
        checkOutput("reset_state", state_o, '0);
        checkOutput("reset_valid", 320'(valid_o), 320'd0);

        // All-zero input: only the S2 slice is set.
        applyStimulus(1'b0, 1'b1, '0);
        exp_s    = '0;
        exp_s[2] = 64'hFFFFFFFFFFFFFFFF;
        checkOutput("zero_state", state_o, exp_s);
        checkOutput("zero_valid", 320'(valid_o), 320'd1);

        // With enable low, the output holds and valid drops.
        applyStimulus(1'b0, 1'b0, random_state());
        checkOutput("hold_state", state_o, exp_s);
        checkOutput("hold_valid", 320'(valid_o), 320'd0);

        // All-ones input gives 10111 in every column.
        applyStimulus(1'b0, 1'b1, {5{64'hFFFFFFFFFFFFFFFF}});
        exp_s[0] = 64'hFFFFFFFFFFFFFFFF;
        exp_s[1] = 64'h0;
        exp_s[2] = 64'hFFFFFFFFFFFFFFFF;
        exp_s[3] = 64'hFFFFFFFFFFFFFFFF;
        exp_s[4] = 64'hFFFFFFFFFFFFFFFF;
        checkOutput("ones_state", state_o, exp_s);

        // A single active column (x = 1) among zero columns.
        in_s     = '0;
        in_s[4]  = 64'h1;
        applyStimulus(1'b0, 1'b1, in_s);
        exp_s[0] = 64'h0;
        exp_s[1] = 64'h1;
        exp_s[2] = 64'hFFFFFFFFFFFFFFFE;
        exp_s[3] = 64'h1;
        exp_s[4] = 64'h1;
        checkOutput("single_col", state_o, exp_s);

        // Ascon-128 initialisation state after constant addition.
        in_s[0] = 64'h80400c0600000000;
        in_s[1] = 64'h8a55114d1cb6a9a2;
        in_s[2] = 64'hbe263d4d7aecaa0f;
        in_s[3] = 64'h4ed0ec0b98c529b7;
        in_s[4] = 64'hc8cddf37bcd0284a;
        applyStimulus(1'b0, 1'b1, in_s);
        checkOutput("init_vector", state_o, model(in_s));
        checkOutput("init_msb_col",
                    320'({state_o[0][63], state_o[1][63], state_o[2][63],
                          state_o[3][63], state_o[4][63]}),
                    320'(5'b01010));

        // Streaming: sweep every column through all 32 values back to back.
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, 1'b1, sweep_state(5'(k)));
            checkOutput($sformatf("stream_state_%0d", k), state_o,
                        sweep_state(sbox_ref(5'(k))));
            checkOutput($sformatf("stream_valid_%0d", k), 320'(valid_o), 320'd1);
        end

        // A reset pulse in the middle of a stream discards the result.
        applyStimulus(1'b0, 1'b1, sweep_state(5'd9));
        prev_out = state_o;
        checkOutput("pre_reset", prev_out, sweep_state(5'h05));
        applyStimulus(1'b1, 1'b1, sweep_state(5'd13));
        checkOutput("midreset_state", state_o, '0);
        checkOutput("midreset_valid", 320'(valid_o), 320'd0);
        applyStimulus(1'b0, 1'b1, sweep_state(5'd13));
        checkOutput("post_reset_state", state_o, sweep_state(5'h03));
        checkOutput("post_reset_valid", 320'(valid_o), 320'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
